i2c_master_wr: RTL
==================

Name: i2c_master_wr

Overview:
Parametrised I2C master write engine with open-drain SCL/SDA control. It generates START, a 7-bit address with R/W=0, and a burst of N data bytes. Data bytes arrive on a valid/ready stream; the engine samples the slave ACK after every byte and generates STOP. It sits between a register/command front-end and the board I2C pads, and adds real bus timing, ACK checking, multi-byte bursts and stall handling.

Parameters:
CLK_DIV, 25, clk cycles per SCL quarter-period (≥2); SCL period = 4*CLK_DIV clk
MAX_BYTES, 16, maximum burst length; sets width of nbytes as CNT_W = $clog2(MAX_BYTES+1)
ADDR_W, 7, slave address width (only 7 supported; parameter kept for package symmetry)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_start  in  1  one-cycle request to begin a transaction; ignored while busy
cmd_addr  in  ADDR_W  slave address, latched on accepted cmd_start
cmd_nbytes  in  CNT_W  data bytes to write, latched on accepted cmd_start; 0 = address-only probe
wr_data  in  8  next data byte
wr_valid  in  1  wr_data valid
wr_ready  out  1  one-cycle pulse when wr_data is consumed
busy  out  1  high from accepted cmd_start until done
done  out  1  one-cycle pulse when STOP completes
nack  out  1  sticky: slave NACKed in last transaction; cleared on next accepted cmd_start
scl_oe  out  1  1 = drive SCL low; 0 = release (pull-up high)
sda_oe  out  1  1 = drive SDA low; 0 = release
sda_i  in  1  SDA pad input, already synchronised externally

Behaviour:
- Reset: state=IDLE, scl_oe=0, sda_oe=0, busy=0, done=0, nack=0, wr_ready=0, quarter counter=0. A reset mid-transaction releases both lines on the next edge. No STOP is generated.
- Quarter tick: the counter runs 0..CLK_DIV-1 only while busy, and a tick fires at terminal count. All bus changes happen on ticks.
- Bit slot = 4 quarters: Q0 SCL low and SDA updated; Q1 SCL low; Q2 SCL released; Q3 SCL high. The ACK or any read bit is sampled from sda_i at the Q2→Q3 tick.
- States:
  - IDLE: lines released. On cmd_start, latch addr and nbytes, clear nack, set busy, go to START.
  - START: 4 quarters. Q0–Q1 SDA and SCL released. Q2 SDA low with SCL high (START condition). Q3 SCL low. Then go to ADDR.
  - ADDR: 8 bit slots, MSB first: addr[6:0] followed by R/W=0. Bit counter runs 7→0. Then go to ACK_A.
  - ACK_A: 1 slot with SDA released. If the sample is 1, set nack and go to STOP. Otherwise go to DATA if nbytes≠0, else STOP.
  - DATA: at entry Q0, the engine requires wr_valid. If wr_valid is low, it stalls with SCL held low, SDA unchanged and the quarter counter frozen, until wr_valid goes high. The byte is latched with a one-cycle wr_ready pulse. It then sends 8 slots MSB first and goes to ACK_D.
  - ACK_D: 1 slot with SDA released. The remaining count is decremented. On NACK, set nack and go to STOP. If remaining=0, go to STOP. Otherwise go to DATA.
  - STOP: 4 quarters. Q0 SDA low, SCL low. Q1 SCL released. Q2 SDA released with SCL high (STOP condition). Q3 idle. At the end, pulse done, clear busy, go to IDLE.
- Byte counts:
  - cmd_nbytes > MAX_BYTES is clamped to MAX_BYTES.
  - Bit and byte counters never wrap; the decrement only occurs when the value is nonzero.
- cmd_start while busy is dropped with no effect. cmd_start in the same cycle as done is also ignored. A new transaction is accepted from IDLE only, one cycle later.
- SDA changes only while SCL is low, except at the START and STOP edges.
- Transaction length without stalls: (8 + 36*(1+nbytes)) quarters.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP)
  - quarter-phase constants Q0..Q3
  - R/W bit constants (I2C_WR=0, I2C_RD=1)
- Sub-module i2c_qtick: parametrised CLK_DIV divider with enable/freeze input and a tick output. It is reused by a future read engine.

Test Plan:
- CLK_DIV=4, addr=0x50, nbytes=1, data=0xAA, slave ACKs → bus monitor decodes START, 0xA0, ACK, 0xAA, ACK, STOP. done pulses 320 clks after cmd_start; nack=0; wr_ready pulses once.
- addr=0x3C, sda_i held high (no slave) → NACK detected at ACK_A, STOP follows, nack=1, no wr_ready, done after 8+36 quarters.
- nbytes=3, data 0x11/0x22/0x33 with wr_valid withheld for 50 clks before byte 2 → SCL stays low for the stall, bytes appear in order, three wr_ready pulses, no glitch on SDA while SCL is high.
- Slave NACKs the 2nd of 4 bytes → STOP immediately after that ACK slot, only 2 wr_ready pulses, nack=1.
- reset asserted mid-ADDR (bit 4) → next cycle scl_oe=sda_oe=0, busy=0, done never pulses. A following transaction to 0x50 completes normally.
- cmd_start pulsed again while busy, and once in the done cycle → both ignored. Only one transaction appears on the bus. nbytes=0 probe → START, address, ACK, STOP, with no data phase.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, quarter-phase and R/W constants for the I2C engines
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP} state_e;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;
endpackage

// File: rtl/i2c_qtick.sv
// i2c_qtick: CLK_DIV quarter-period divider with clear and freeze
module i2c_qtick #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int QW = $clog2(CLK_DIV);
  logic [QW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = !clr_i && en_i && cnt_q == QW'(CLK_DIV - 1);
    cnt_d = clr_i ? '0 : tick_o ? '0 : en_i ? cnt_q + QW'(1) : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/i2c_master_wr.sv
// i2c_master_wr: open-drain I2C write engine (START, address, N-byte burst, ACK check, STOP)
module i2c_master_wr
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int MAX_BYTES = 16,
  parameter int ADDR_W = 7,
  localparam int CNT_W = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_nbytes,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              nack,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              sda_i
);
  state_e state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] bit_q, bit_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] byte_q, byte_d, frame;
  logic have_q, have_d, smp_q, smp_d, nack_q, nack_d, busy_q, busy_d;
  logic scl_q, scl_d, sda_q, sda_d, done_q, done_d, rdy_q, rdy_d;
  logic tick, need;
  assign need = state_q == DATA && ph_q == Q0 && bit_q == 3'd7 && !have_q;
  assign frame = {addr_q, I2C_WR};
  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk(clk), .reset(reset), .clr_i(!busy_q), .en_i(!(need && !wr_valid)), .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    ph_d = ph_q;
    bit_d = bit_q;
    rem_d = rem_q;
    addr_d = addr_q;
    byte_d = byte_q;
    have_d = have_q;
    smp_d = smp_q;
    nack_d = nack_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rdy_d = 1'b0;
    if (state_q == IDLE && cmd_start && !done_q) begin
      addr_d = cmd_addr;
      rem_d = cmd_nbytes > CNT_W'(MAX_BYTES) ? CNT_W'(MAX_BYTES) : cmd_nbytes;
      nack_d = 1'b0;
      busy_d = 1'b1;
      state_d = START;
      ph_d = Q0;
      bit_d = 3'd7;
    end
    if (need && wr_valid) begin
      byte_d = wr_data;
      have_d = 1'b1;
      rdy_d = 1'b1;
    end
    if (tick) begin
      ph_d = ph_q + 2'd1;
      smp_d = ph_q == Q2 ? sda_i : smp_q;
      if (ph_q == Q3)
        case (state_q)
          START: state_d = ADDR;
          ADDR, DATA: begin
            bit_d = bit_q != 3'd0 ? bit_q - 3'd1 : 3'd7;
            state_d = bit_q != 3'd0 ? state_q : state_q == ADDR ? ACK_A : ACK_D;
            have_d = bit_q != 3'd0 && have_q;
          end
          ACK_A: begin
            nack_d = nack_q | smp_q;
            state_d = !smp_q && rem_q != '0 ? DATA : STOP;
          end
          ACK_D: begin
            nack_d = nack_q | smp_q;
            rem_d = rem_q != '0 ? rem_q - CNT_W'(1) : rem_q;
            state_d = !smp_q && rem_q > CNT_W'(1) ? DATA : STOP;
          end
          STOP: begin
            state_d = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
          default: ;
        endcase
    end
  end
  // Line drive follows the current slot; a stalled byte keeps SDA where it was
  always_comb begin
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (state_q)
      START: begin
        scl_d = ph_q == Q3;
        sda_d = ph_q == Q2 || ph_q == Q3;
      end
      ADDR, DATA, ACK_A, ACK_D: begin
        scl_d = !ph_q[1];
        sda_d = state_q == ADDR ? !frame[bit_q] : state_q == DATA ? (need ? sda_q : !byte_q[bit_q]) : 1'b0;
      end
      STOP: begin
        scl_d = ph_q == Q0;
        sda_d = ph_q == Q0 || ph_q == Q1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ph_q <= Q0;
      bit_q <= 3'd7;
      rem_q <= '0;
      addr_q <= '0;
      byte_q <= '0;
      have_q <= 1'b0;
      smp_q <= 1'b0;
      nack_q <= 1'b0;
      busy_q <= 1'b0;
      scl_q <= 1'b0;
      sda_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      bit_q <= bit_d;
      rem_q <= rem_d;
      addr_q <= addr_d;
      byte_q <= byte_d;
      have_q <= have_d;
      smp_q <= smp_d;
      nack_q <= nack_d;
      busy_q <= busy_d;
      scl_q <= scl_d;
      sda_q <= sda_d;
      done_q <= done_d;
      rdy_q <= rdy_d;
    end
  end
  assign wr_ready = rdy_q;
  assign busy = busy_q;
  assign done = done_q;
  assign nack = nack_q;
  assign scl_oe = scl_q;
  assign sda_oe = sda_q;
endmodule
